axi_read_arbiter: RTL and testbench

- Shares one DRAM-side AXI read channel (address and data) between two cache masters: master 0 is the i-cache, master 1 is the d-cache.
- Arbitration is round-robin. Exactly one burst is outstanding at a time.
- R beats are routed back to the master that owns the burst.
- Sits between the cache miss handlers and the memory controller.

---
 rtl/axi_read_arbiter_pkg.sv | 12 +
 rtl/axi_read_address.sv | 14 +
 rtl/axi_read_data.sv | 14 +
 rtl/axi_rr_pick.sv | 21 ++
 rtl/axi_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi_read_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and widths for the two-master AXI read arbiter.
package axi_read_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ID_WIDTH        = 4;
  localparam int unsigned LEN_WIDTH       = 4;
  localparam int unsigned AXI_ARB_MASTERS = 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} axi_arb_state_t;

endpackage

// File: rtl/axi_read_address.sv
// AXI read-address channel bundle; master drives the request, slave returns arready.
interface axi_read_address;
  import axi_read_arbiter_pkg::*;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [LEN_WIDTH-1:0]  arlen;

  modport master (output arvalid, araddr, arid, arlen, input arready);
  modport slave  (input arvalid, araddr, arid, arlen, output arready);

endinterface

// File: rtl/axi_read_data.sv
// AXI read-data channel bundle; slave drives the beats, master returns rready.
interface axi_read_data;
  import axi_read_arbiter_pkg::*;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  rlast;

  modport master (input rvalid, rdata, rid, rlast, output rready);
  modport slave  (output rvalid, rdata, rid, rlast, input rready);

endinterface

// File: rtl/axi_rr_pick.sv
// Two-input round-robin picker; purely combinational, pointer held by the caller.
module axi_rr_pick
  import axi_read_arbiter_pkg::*;
(
  input  logic [AXI_ARB_MASTERS-1:0] req,
  input  logic                       last,
  output logic                       gnt_valid,
  output logic                       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    // Under contention the master that was not granted last time wins.
    if (&req) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read channel between i-cache (0) and d-cache (1),
// one burst outstanding at a time, R beats steered back to the burst owner.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned BEAT_CHECK = 1,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_read_address.slave  m0_ar,
  axi_read_data.slave     m0_r,
  axi_read_address.slave  m1_ar,
  axi_read_data.slave     m1_r,
  axi_read_address.master mem_ar,
  axi_read_data.master    mem_r,
  output logic            busy,
  output logic            owner,
  output logic            protocol_error
);

  localparam logic ResetLast = (RESET_PRIO == 0);

  axi_arb_state_t        state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic [AXI_ARB_MASTERS-1:0] req;
  logic gnt_valid, gnt_idx, grant;
  logic in_data, owner_rready, beat_fire, len_bad;

  assign req = {m1_ar.arvalid, m0_ar.arvalid};

  axi_rr_pick u_rr_pick (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Qualified with rst_n so no handshake is offered while reset is held.
  assign grant         = rst_n && (state_q == ARB_IDLE) && gnt_valid;
  assign m0_ar.arready = grant && !gnt_idx;
  assign m1_ar.arready = grant && gnt_idx;

  assign mem_ar.arvalid = (state_q == ARB_ADDR);
  assign mem_ar.araddr  = araddr_q;
  assign mem_ar.arid    = arid_q;
  assign mem_ar.arlen   = arlen_q;

  assign in_data      = (state_q == ARB_DATA);
  assign owner_rready = owner_q ? m1_r.rready : m0_r.rready;
  assign mem_r.rready = in_data && owner_rready;

  assign m0_r.rvalid = in_data && !owner_q && mem_r.rvalid;
  assign m0_r.rlast  = in_data && !owner_q && mem_r.rlast;
  assign m0_r.rdata  = mem_r.rdata;
  assign m0_r.rid    = mem_r.rid;
  assign m1_r.rvalid = in_data && owner_q && mem_r.rvalid;
  assign m1_r.rlast  = in_data && owner_q && mem_r.rlast;
  assign m1_r.rdata  = mem_r.rdata;
  assign m1_r.rid    = mem_r.rid;

  assign beat_fire = mem_r.rvalid && mem_r.rready;
  // Early RLAST, or the expected final beat arriving without RLAST.
  assign len_bad   = mem_r.rlast ? (beat_cnt_q != arlen_q) : (beat_cnt_q == arlen_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    err_d      = err_q;
    araddr_d   = araddr_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d    = ARB_ADDR;
          owner_d    = gnt_idx;
          beat_cnt_d = '0;
          araddr_d   = gnt_idx ? m1_ar.araddr : m0_ar.araddr;
          arid_d     = gnt_idx ? m1_ar.arid : m0_ar.arid;
          arlen_d    = gnt_idx ? m1_ar.arlen : m0_ar.arlen;
        end
      end
      ARB_ADDR: begin
        if (mem_ar.arready) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if ((BEAT_CHECK != 0) && len_bad) begin
            err_d = 1'b1;
          end
          if (mem_r.rlast) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 1'b0;
      last_q     <= ResetLast;
      err_q      <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      err_q      <= err_d;
      araddr_q   <= araddr_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy           = (state_q != ARB_IDLE);
  assign owner          = owner_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: stimulus pushes expected grants/AR/R beats into
// queues, a forked monitor pops and compares whenever the DUT presents a handshake.
module tb_axi_read_arbiter
  import axi_read_arbiter_pkg::*;
;

  localparam int unsigned ArW = ADDR_WIDTH + ID_WIDTH + LEN_WIDTH;
  localparam int unsigned RW  = DATA_WIDTH + ID_WIDTH + 1;

  logic clk;
  logic rst_n;
  logic busy, owner, protocol_error;

  axi_read_address m0_ar_if ();
  axi_read_data    m0_r_if ();
  axi_read_address m1_ar_if ();
  axi_read_data    m1_r_if ();
  axi_read_address mem_ar_if ();
  axi_read_data    mem_r_if ();

  axi_read_arbiter #(
    .BEAT_CHECK (1),
    .RESET_PRIO (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_ar          (m0_ar_if),
    .m0_r           (m0_r_if),
    .m1_ar          (m1_ar_if),
    .m1_r           (m1_r_if),
    .mem_ar         (mem_ar_if),
    .mem_r          (mem_r_if),
    .busy           (busy),
    .owner          (owner),
    .protocol_error (protocol_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  bit           gnt_q[$];
  logic [ArW-1:0] ar_q[$];
  logic [RW-1:0]  r0_q[$];
  logic [RW-1:0]  r1_q[$];

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endfunction

  function automatic void chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected or missing event, required the expected one", name);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m0_ar_if.arready || m1_ar_if.arready) begin
          chk1("grant_onehot", m0_ar_if.arready && m1_ar_if.arready, 1'b0);
          chk1("grant_has_req", m1_ar_if.arready ? m1_ar_if.arvalid : m0_ar_if.arvalid, 1'b1);
          if (gnt_q.size() == 0) miss("unexpected_grant");
          else chk1("grant_idx", m1_ar_if.arready, gnt_q.pop_front());
        end
        if (mem_ar_if.arvalid && mem_ar_if.arready) begin
          if (ar_q.size() == 0) miss("unexpected_mem_ar");
          else chkw("mem_ar_fields", 64'({mem_ar_if.araddr, mem_ar_if.arid, mem_ar_if.arlen}),
                    64'(ar_q.pop_front()));
        end
        if (m0_r_if.rvalid) begin
          if (r0_q.size() == 0) miss("m0_spurious_rvalid");
          else if (m0_r_if.rready)
            chkw("m0_r_beat", 64'({m0_r_if.rdata, m0_r_if.rid, m0_r_if.rlast}),
                 64'(r0_q.pop_front()));
        end else if (m0_r_if.rlast) miss("m0_rlast_without_rvalid");
        if (m1_r_if.rvalid) begin
          if (r1_q.size() == 0) miss("m1_spurious_rvalid");
          else if (m1_r_if.rready)
            chkw("m1_r_beat", 64'({m1_r_if.rdata, m1_r_if.rid, m1_r_if.rlast}),
                 64'(r1_q.pop_front()));
        end else if (m1_r_if.rlast) miss("m1_rlast_without_rvalid");
      end
    end
  endtask

  task automatic req(input bit m, input logic [ADDR_WIDTH-1:0] a, input logic [3:0] id,
                     input logic [3:0] len);
    if (m) begin
      m1_ar_if.arvalid = 1'b1; m1_ar_if.araddr = a; m1_ar_if.arid = id; m1_ar_if.arlen = len;
    end else begin
      m0_ar_if.arvalid = 1'b1; m0_ar_if.araddr = a; m0_ar_if.arid = id; m0_ar_if.arlen = len;
    end
  endtask

  task automatic expect_ar(input bit m, input logic [ADDR_WIDTH-1:0] a, input logic [3:0] id,
                           input logic [3:0] len);
    gnt_q.push_back(m);
    ar_q.push_back({a, id, len});
  endtask

  task automatic wait_grant(input bit m);
    int n = 0;
    @(negedge clk);
    while (!(m ? m1_ar_if.arready : m0_ar_if.arready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!(m ? m1_ar_if.arready : m0_ar_if.arready)) miss("grant_timeout");
    @(posedge clk);
    #1;
    if (m) m1_ar_if.arvalid = 1'b0;
    else m0_ar_if.arvalid = 1'b0;
  endtask

  task automatic mem_ar_accept(input int stall, input logic [ArW-1:0] exp);
    int n = 0;
    while (!mem_ar_if.arvalid && n < 20) begin
      n++;
      tick();
    end
    if (!mem_ar_if.arvalid) miss("mem_arvalid_timeout");
    for (int i = 0; i < stall; i++) begin
      #1;
      chk1("stall_mem_arvalid", mem_ar_if.arvalid, 1'b1);
      chkw("stall_mem_ar_fields", 64'({mem_ar_if.araddr, mem_ar_if.arid, mem_ar_if.arlen}),
           64'(exp));
      chk1("stall_m1_arready", m1_ar_if.arready, 1'b0);
      tick();
    end
    mem_ar_if.arready = 1'b1;
    tick();
    mem_ar_if.arready = 1'b0;
  endtask

  task automatic mem_present(input bit m, input logic [DATA_WIDTH-1:0] d, input logic [3:0] id,
                             input logic last);
    if (m) r1_q.push_back({d, id, last});
    else r0_q.push_back({d, id, last});
    mem_r_if.rvalid = 1'b1;
    mem_r_if.rdata  = d;
    mem_r_if.rid    = id;
    mem_r_if.rlast  = last;
  endtask

  task automatic mem_wait_hs();
    int n = 0;
    @(negedge clk);
    while (!mem_r_if.rready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!mem_r_if.rready) miss("beat_timeout");
    tick();
    mem_r_if.rvalid = 1'b0;
    mem_r_if.rlast  = 1'b0;
  endtask

  task automatic mem_beat(input bit m, input logic [DATA_WIDTH-1:0] d, input logic [3:0] id,
                          input logic last);
    mem_present(m, d, id, last);
    mem_wait_hs();
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst_n = 1'b1;
    m0_ar_if.arvalid = 1'b0; m0_ar_if.araddr = '0; m0_ar_if.arid = '0; m0_ar_if.arlen = '0;
    m1_ar_if.arvalid = 1'b0; m1_ar_if.araddr = '0; m1_ar_if.arid = '0; m1_ar_if.arlen = '0;
    m0_r_if.rready = 1'b1;
    m1_r_if.rready = 1'b1;
    mem_ar_if.arready = 1'b0;
    mem_r_if.rvalid = 1'b0; mem_r_if.rdata = '0; mem_r_if.rid = '0; mem_r_if.rlast = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_protocol_error", protocol_error, 1'b0);
    chk1("rst_mem_arvalid", mem_ar_if.arvalid, 1'b0);
    chk1("rst_mem_rready", mem_r_if.rready, 1'b0);
    chkw("rst_mem_ar_fields", 64'({mem_ar_if.araddr, mem_ar_if.arid, mem_ar_if.arlen}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Contention after reset: m0, then m1, then m0 again, then m1.
    req(1'b0, 32'h200, 4'd2, 4'd1);
    req(1'b1, 32'h300, 4'd5, 4'd0);
    expect_ar(1'b0, 32'h200, 4'd2, 4'd1);
    #1;
    chk1("cont_m0_first", m0_ar_if.arready, 1'b1);
    chk1("cont_m1_held", m1_ar_if.arready, 1'b0);
    wait_grant(1'b0);
    mem_ar_accept(0, '0);
    mem_beat(1'b0, 32'hA0, 4'd2, 1'b0);
    #1;
    chk1("cont_m1_waits_in_data", m1_ar_if.arready, 1'b0);
    mem_beat(1'b0, 32'hA1, 4'd2, 1'b1);
    expect_ar(1'b1, 32'h300, 4'd5, 4'd0);
    #1;
    chk1("cont_m1_granted_next_idle", m1_ar_if.arready, 1'b1);
    chk1("cont_idle_not_busy", busy, 1'b0);
    wait_grant(1'b1);
    chk1("cont_owner_m1", owner, 1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'hB0, 4'd5, 1'b1);
    req(1'b0, 32'h400, 4'd3, 4'd0);
    req(1'b1, 32'h500, 4'd6, 4'd0);
    expect_ar(1'b0, 32'h400, 4'd3, 4'd0);
    #1;
    chk1("cont_alternate_m0", m0_ar_if.arready, 1'b1);
    wait_grant(1'b0);
    mem_ar_accept(0, '0);
    mem_beat(1'b0, 32'hC0, 4'd3, 1'b1);
    expect_ar(1'b1, 32'h500, 4'd6, 4'd0);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'hC1, 4'd6, 1'b1);

    // Single i-cache read of four beats.
    req(1'b0, 32'h100, 4'd1, 4'd3);
    expect_ar(1'b0, 32'h100, 4'd1, 4'd3);
    #1;
    chk1("single_arready_same_cycle", m0_ar_if.arready, 1'b1);
    chk1("single_mem_arvalid_not_yet", mem_ar_if.arvalid, 1'b0);
    wait_grant(1'b0);
    chk1("single_mem_arvalid_next", mem_ar_if.arvalid, 1'b1);
    chk1("single_busy", busy, 1'b1);
    mem_ar_accept(0, '0);
    for (int b = 0; b < 4; b++) mem_beat(1'b0, 32'hD0 + 32'(b), 4'd1, (b == 3));
    chk1("single_busy_after_rlast", busy, 1'b0);
    chk1("single_owner", owner, 1'b0);

    // Owner back-pressure for three cycles mid-burst.
    req(1'b1, 32'h600, 4'd7, 4'd3);
    expect_ar(1'b1, 32'h600, 4'd7, 4'd3);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'hE0, 4'd7, 1'b0);
    m1_r_if.rready = 1'b0;
    mem_present(1'b1, 32'hE1, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_mem_rready_low", mem_r_if.rready, 1'b0);
      chk1("bp_m1_rvalid_held", m1_r_if.rvalid, 1'b1);
      tick();
    end
    m1_r_if.rready = 1'b1;
    mem_wait_hs();
    mem_beat(1'b1, 32'hE2, 4'd7, 1'b0);
    mem_beat(1'b1, 32'hE3, 4'd7, 1'b1);
    chk1("bp_no_protocol_error", protocol_error, 1'b0);

    // DRAM address stall with the other master waiting.
    req(1'b0, 32'h700, 4'd8, 4'd0);
    expect_ar(1'b0, 32'h700, 4'd8, 4'd0);
    wait_grant(1'b0);
    req(1'b1, 32'h800, 4'd9, 4'd0);
    mem_ar_accept(5, {32'h700, 4'd8, 4'd0});
    mem_beat(1'b0, 32'hF0, 4'd8, 1'b1);
    expect_ar(1'b1, 32'h800, 4'd9, 4'd0);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'hF1, 4'd9, 1'b1);

    // Early RLAST on the second beat of a four-beat burst.
    req(1'b0, 32'h900, 4'd4, 4'd3);
    expect_ar(1'b0, 32'h900, 4'd4, 4'd3);
    wait_grant(1'b0);
    mem_ar_accept(0, '0);
    mem_beat(1'b0, 32'h60, 4'd4, 1'b0);
    chk1("len_no_error_yet", protocol_error, 1'b0);
    mem_beat(1'b0, 32'h61, 4'd4, 1'b1);
    chk1("len_error_set", protocol_error, 1'b1);
    chk1("len_back_to_idle", busy, 1'b0);
    req(1'b1, 32'hA00, 4'd2, 4'd0);
    expect_ar(1'b1, 32'hA00, 4'd2, 4'd0);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'h70, 4'd2, 1'b1);
    chk1("len_error_sticky", protocol_error, 1'b1);

    // Asynchronous reset in the middle of a data phase.
    req(1'b1, 32'hB00, 4'd1, 4'd3);
    expect_ar(1'b1, 32'hB00, 4'd1, 4'd3);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'h80, 4'd1, 1'b0);
    mem_r_if.rvalid = 1'b1;
    mem_r_if.rdata  = 32'h81;
    mem_r_if.rlast  = 1'b1;
    req(1'b0, 32'hBAD, 4'd0, 4'd0);
    #1;
    chk1("arst_beat_visible", m1_r_if.rvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_owner", owner, 1'b0);
    chk1("arst_protocol_error", protocol_error, 1'b0);
    chk1("arst_mem_arvalid", mem_ar_if.arvalid, 1'b0);
    chk1("arst_mem_rready", mem_r_if.rready, 1'b0);
    chk1("arst_m1_rvalid", m1_r_if.rvalid, 1'b0);
    chk1("arst_m1_rlast", m1_r_if.rlast, 1'b0);
    chk1("arst_m0_arready", m0_ar_if.arready, 1'b0);
    chkw("arst_ar_fields", 64'({mem_ar_if.araddr, mem_ar_if.arid, mem_ar_if.arlen}), 64'(0));
    mem_r_if.rvalid = 1'b0;
    mem_r_if.rlast  = 1'b0;
    m0_ar_if.arvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    req(1'b0, 32'hC00, 4'd15, 4'd1);
    req(1'b1, 32'hD00, 4'd3, 4'd0);
    expect_ar(1'b0, 32'hC00, 4'd15, 4'd1);
    #1;
    chk1("post_rst_m0_first", m0_ar_if.arready, 1'b1);
    wait_grant(1'b0);
    mem_ar_accept(0, '0);
    mem_beat(1'b0, 32'h90, 4'd15, 1'b0);
    mem_beat(1'b0, 32'h91, 4'd15, 1'b1);
    expect_ar(1'b1, 32'hD00, 4'd3, 4'd0);
    wait_grant(1'b1);
    mem_ar_accept(0, '0);
    mem_beat(1'b1, 32'h92, 4'd3, 1'b1);
    chk1("post_rst_no_error", protocol_error, 1'b0);

    tick();
    tick();
    chkw("drain_gnt_q", 64'(gnt_q.size()), 64'(0));
    chkw("drain_ar_q", 64'(ar_q.size()), 64'(0));
    chkw("drain_r0_q", 64'(r0_q.size()), 64'(0));
    chkw("drain_r1_q", 64'(r1_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
